// File: rtl/fmul_norm_round.sv
// Normalise/round/pack stage for the binary32 multiplier: 2.48 product -> IEEE-754 single.
// Two-stage valid/ready pipeline; define FNR_FLAGS_EN to build the {overflow, underflow, inexact} flags.
module fmul_norm_round #(
    parameter int EXPW = 10
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sign,
    input  logic [EXPW-1:0] in_exp,
    input  logic [49:0]     in_prod,
    input  logic [1:0]      in_class,
    input  logic [1:0]      in_rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [2:0]      out_flags
);
    localparam int EW = EXPW + 1;
    localparam logic signed [EW-1:0] E_MAX  = EW'(255);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;
    localparam logic [1:0] RM_RNE   = 2'b00;
    localparam logic [1:0] RM_RU    = 2'b10;
    localparam logic [1:0] RM_RD    = 2'b11;

    typedef struct packed {
        logic          sign;
        logic [1:0]    cls;
        logic [1:0]    rm;
        logic [23:0]   m;
        logic          inc;
        logic [EW-1:0] e;
    } s1_t;

    logic [2:1] vld_pipe;
    logic       adv1, adv2;
    s1_t        s1_d, s1_q;
    logic       g, s;
    logic [31:0] res_d, res_q;

    assign adv2      = ~vld_pipe[2] | out_ready;
    assign adv1      = ~vld_pipe[1] | adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];
    assign out_result = res_q;

    // Stage 1: pick the 24-bit significand window and decide the rounding increment.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.cls  = in_class;
        s1_d.rm   = in_rm;
        s1_d.e    = {in_exp[EXPW-1], in_exp} + {{(EW-1){1'b0}}, in_prod[49]};
        if (in_prod[49]) begin
            s1_d.m = in_prod[49:26];
            g      = in_prod[25];
            s      = |in_prod[24:0];
        end else begin
            s1_d.m = in_prod[48:25];
            g      = in_prod[24];
            s      = |in_prod[23:0];
        end
        case (in_rm)
            RM_RNE:  s1_d.inc = g & (s | s1_d.m[0]);
            RM_RU:   s1_d.inc = ~in_sign & (g | s);
            RM_RD:   s1_d.inc = in_sign & (g | s);
            default: s1_d.inc = 1'b0;
        endcase
    end

    logic                 frac_c, carry, ovf_inf;
    logic [22:0]          frac;
    logic signed [EW-1:0] e2;
    logic [2:0]           flg_d;
    logic                 s1_inx;

    // Stage 2: the 24-bit increment carries out only when the whole significand was all ones.
    always_comb begin
        {frac_c, frac} = {1'b0, s1_q.m[22:0]} + {23'd0, s1_q.inc};
        carry   = frac_c & s1_q.m[23];
        e2      = s1_q.e + {{(EW-1){1'b0}}, carry};
        ovf_inf = (s1_q.rm == RM_RNE) | ((s1_q.rm == RM_RU) & ~s1_q.sign) |
                  ((s1_q.rm == RM_RD) & s1_q.sign);
        res_d   = {s1_q.sign, e2[7:0], frac};
        flg_d   = {2'b00, s1_inx};
        if (s1_q.cls == CLS_NAN) begin
            res_d = 32'h7FC0_0000;
            flg_d = 3'b000;
        end else if (s1_q.cls == CLS_INF) begin
            res_d = {s1_q.sign, 8'hFF, 23'h0};
            flg_d = 3'b000;
        end else if (s1_q.cls == CLS_ZERO) begin
            res_d = {s1_q.sign, 31'h0};
            flg_d = 3'b000;
        end else if (e2 >= E_MAX) begin
            res_d = ovf_inf ? {s1_q.sign, 8'hFF, 23'h0} : {s1_q.sign, 31'h7F7F_FFFF};
            flg_d = 3'b101;
        end else if (e2 <= E_ZERO) begin
            // Flush to zero always discards a nonzero value, so it is inexact too.
            res_d = {s1_q.sign, 31'h0};
            flg_d = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
        end else begin
            if (adv1) vld_pipe[1] <= in_valid;
            if (adv1 && in_valid) s1_q <= s1_d;
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) res_q <= res_d;
            end
        end
    end

`ifdef FNR_FLAGS_EN
    logic [2:0] flags_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_inx  <= 1'b0;
            flags_q <= '0;
        end else begin
            if (adv1 && in_valid) s1_inx <= g | s;
            if (adv2 && vld_pipe[1]) flags_q <= flg_d;
        end
    end
    assign out_flags = flags_q;
`else
    assign s1_inx    = 1'b0;
    assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fmul_norm_round.sv
// Directed-vector bench for fmul_norm_round: rounding modes, specials, overflow/underflow,
// stall/backpressure ordering and asynchronous reset mid-stream.
module tb_fmul_norm_round;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [49:0] in_prod = '0;
    logic [1:0]  in_class = '0;
    logic [1:0]  in_rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int failures = 0;

`ifdef FNR_FLAGS_EN
    localparam logic [2:0] FMASK = 3'b111;
`else
    localparam logic [2:0] FMASK = 3'b000;
`endif

    fmul_norm_round #(.EXPW(10)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod),
        .in_class(in_class), .in_rm(in_rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [49:0] p;
        logic [1:0]  c;
        logic [1:0]  r;
        logic [31:0] res;
        logic [2:0]  f;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic [9:0] e, input logic [49:0] p, input logic [1:0] c,
                       input logic [1:0] r, input logic [31:0] res, input logic [2:0] f, input string name);
        vec_t v;
        v.s = s; v.e = e; v.p = p; v.c = c; v.r = r; v.res = res; v.f = f; v.name = name;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_sign = v.s; in_exp = v.e; in_prod = v.p; in_class = v.c; in_rm = v.r;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b000) begin
            failures++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b, want 0/00000000/000",
                     out_valid, out_result, out_flags);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        add(0, 10'd127, 50'h3FFFFFB000001, 2'b00, 2'b00, 32'h407FFFFF, 3'b001, "allones_rne");
        add(0, 10'd127, 50'h3FFFFFB000001, 2'b00, 2'b01, 32'h407FFFFE, 3'b001, "allones_rz");
        add(0, 10'd127, 50'h3FFFFFB000001, 2'b00, 2'b10, 32'h407FFFFF, 3'b001, "allones_ru");
        add(1, 10'd127, 50'h3FFFFFB000001, 2'b00, 2'b11, 32'hC07FFFFF, 3'b001, "allones_rd_neg");
        add(1, 10'd127, 50'h3FFFFFB000001, 2'b00, 2'b10, 32'hC07FFFFE, 3'b001, "allones_ru_neg");
        add(0, 10'd127, 50'h1000000000000, 2'b00, 2'b00, 32'h3F800000, 3'b000, "one");
        add(0, 10'd0,   50'h1000000000000, 2'b00, 2'b00, 32'h00000000, 3'b011, "uflow_pos");
        add(1, 10'd0,   50'h1000000000000, 2'b00, 2'b00, 32'h80000000, 3'b011, "uflow_neg");
        add(0, 10'd1,   50'h1000000000000, 2'b00, 2'b00, 32'h00800000, 3'b000, "min_normal");
        add(0, 10'h3FF, 50'h2000000000000, 2'b00, 2'b00, 32'h00000000, 3'b011, "neg_exp_norm");
        add(0, 10'd127, 50'h1FFFFFF000000, 2'b00, 2'b00, 32'h40000000, 3'b001, "round_carry");
        add(0, 10'd254, 50'h1FFFFFF000000, 2'b00, 2'b00, 32'h7F800000, 3'b101, "carry_ovf");
        add(0, 10'd253, 50'h2000000000000, 2'b00, 2'b00, 32'h7F000000, 3'b000, "max_exp");
        add(0, 10'd254, 50'h2000000000000, 2'b00, 2'b00, 32'h7F800000, 3'b101, "ovf_rne");
        add(0, 10'd254, 50'h2000000000000, 2'b00, 2'b01, 32'h7F7FFFFF, 3'b101, "ovf_rz");
        add(0, 10'd254, 50'h2000000000000, 2'b00, 2'b11, 32'h7F7FFFFF, 3'b101, "ovf_rd_pos");
        add(1, 10'd254, 50'h2000000000000, 2'b00, 2'b10, 32'hFF7FFFFF, 3'b101, "ovf_ru_neg");
        add(1, 10'd254, 50'h2000000000000, 2'b00, 2'b11, 32'hFF800000, 3'b101, "ovf_rd_neg");
        add(0, 10'd254, 50'h2000000000000, 2'b11, 2'b00, 32'h7FC00000, 3'b000, "nan");
        add(1, 10'd127, 50'h1000000000000, 2'b10, 2'b00, 32'hFF800000, 3'b000, "inf_neg");
        add(1, 10'd127, 50'h1000000000000, 2'b01, 2'b00, 32'h80000000, 3'b000, "zero_neg");
        out_ready = 1'b1;
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s_in_ready: got %b want 1", vq[i].name, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== vq[i].res) begin
                failures++;
                $display("FAIL %s_result: valid=%b result=%h want valid=1 result=%h",
                         vq[i].name, out_valid, out_result, vq[i].res);
            end
            checks++;
            if (out_flags !== (vq[i].f & FMASK)) begin
                failures++;
                $display("FAIL %s_flags: got %b want %b", vq[i].name, out_flags, vq[i].f & FMASK);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[3];
        exp_q[0] = 32'h3F800000; exp_q[1] = 32'h40000000; exp_q[2] = 32'h407FFFFF;
        @(negedge clk);
        out_ready = 1'b0;
        drive(vq[5]);  in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept_a: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        drive(vq[10]);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept_b: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        drive(vq[0]);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== exp_q[0]) begin
            failures++;
            $display("FAIL b2b_full: in_ready=%b valid=%b result=%h want 0/1/%h", in_ready, out_valid, out_result, exp_q[0]);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== exp_q[0]) begin
            failures++;
            $display("FAIL b2b_hold: in_ready=%b valid=%b result=%h want 0/1/%h", in_ready, out_valid, out_result, exp_q[0]);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_q[k]) begin
                failures++;
                $display("FAIL b2b_order%0d: valid=%b result=%h want 1/%h", k, out_valid, out_result, exp_q[k]);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream;
        @(negedge clk);
        out_ready = 1'b0;
        drive(vq[0]); in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        clrn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset: valid=%b result=%h flags=%b want 0/00000000/000", out_valid, out_result, out_flags);
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(vq[13]); in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_accept: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_lat1: valid=%b want 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h7F800000 || out_flags !== (3'b101 & FMASK)) begin
            failures++;
            $display("FAIL mid_lat2: valid=%b result=%h flags=%b want 1/7f800000/%b",
                     out_valid, out_result, out_flags, 3'b101 & FMASK);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
